// File: rtl/cache_control.sv
// Write-back, write-allocate control FSM for a 2-way set-associative cache.
// Optional CACHE_STATS_EN adds saturating hit/miss/writeback counters.
module cache_control #(
    parameter int s_index = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_read,
    input  logic       mem_write,
    output logic       mem_resp,
    input  logic [1:0] hit,
    input  logic [1:0] dirty,
    input  logic       lru,
    output logic [1:0] load_tag,
    output logic [1:0] load_valid,
    output logic       valid_in,
    output logic [1:0] load_dirty,
    output logic       dirty_in,
    output logic       load_lru,
    output logic       lru_in,
    output logic [1:0] load_data,
    output logic       data_sel,
    output logic [1:0] addr_sel,
    output logic       pmem_read,
    output logic       pmem_write,
    input  logic       pmem_resp
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] wb_count
`endif
);

    if (s_index < 1) begin : g_bad_index
        $error("cache_control: s_index must be at least 1");
    end

    // Encoding chosen so pmem_read/pmem_write are raw state flop bits.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WRITEBACK = 2'b01,
        FILL      = 2'b10
    } state_t;

    state_t state, next_state;
    logic   victim;
    logic   req, way_hit, miss_start;

    assign req        = mem_read | mem_write;
    assign way_hit    = ~hit[0];
    assign valid_in   = 1'b1;
    assign pmem_read  = state[1];
    assign pmem_write = state[0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            victim <= 1'b0;
        end else begin
            state <= next_state;
            if (miss_start) victim <= lru;
        end
    end

    // Strobes are suppressed while reset is held so the arrays are not disturbed.
    always_comb begin
        next_state = state;
        miss_start = 1'b0;
        mem_resp   = 1'b0;
        load_tag   = 2'b00;
        load_valid = 2'b00;
        load_dirty = 2'b00;
        dirty_in   = 1'b0;
        load_lru   = 1'b0;
        lru_in     = 1'b0;
        load_data  = 2'b00;
        data_sel   = 1'b0;
        addr_sel   = 2'd0;
        if (rst) begin
            unique case (state)
                IDLE: begin
                    if (req && (hit != 2'b00)) begin
                        mem_resp = 1'b1;
                        load_lru = 1'b1;
                        lru_in   = ~way_hit;
                        if (mem_write) begin
                            load_data[way_hit]  = 1'b1;
                            load_dirty[way_hit] = 1'b1;
                            dirty_in            = 1'b1;
                        end
                    end else if (req) begin
                        miss_start = 1'b1;
                        next_state = dirty[lru] ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    addr_sel = victim ? 2'd2 : 2'd1;
                    if (pmem_resp) next_state = FILL;
                end
                FILL: begin
                    if (pmem_resp) begin
                        load_data[victim]  = 1'b1;
                        load_tag[victim]   = 1'b1;
                        load_valid[victim] = 1'b1;
                        load_dirty[victim] = 1'b1;
                        data_sel           = 1'b1;
                        next_state         = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (&c) ? c : c + 32'd1;
    endfunction

    // Remembers that the pending request already missed, so its final hit is not counted.
    logic missed;

    always_ff @(posedge clk) begin
        if (!rst) begin
            missed     <= 1'b0;
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
            wb_count   <= 32'd0;
        end else begin
            if (state == IDLE) missed <= miss_start;
            if (mem_resp && !missed) hit_count <= sat_inc(hit_count);
            if (miss_start) miss_count <= sat_inc(miss_count);
            if (state == WRITEBACK && pmem_resp) wb_count <= sat_inc(wb_count);
        end
    end
`endif

endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_cache_control;

    typedef struct packed {
        logic       mem_resp;
        logic [1:0] load_tag;
        logic [1:0] load_valid;
        logic [1:0] load_dirty;
        logic       dirty_in;
        logic       load_lru;
        logic       lru_in;
        logic [1:0] load_data;
        logic       data_sel;
        logic [1:0] addr_sel;
        logic       pmem_read;
        logic       pmem_write;
        logic       valid_in;
    } out_t;

    logic       clk = 1'b0;
    logic       rst, mem_read, mem_write, lru, pmem_resp;
    logic [1:0] hit, dirty;
    logic       mem_resp, valid_in, dirty_in, load_lru, lru_in, data_sel, pmem_read, pmem_write;
    logic [1:0] load_tag, load_valid, load_dirty, load_data, addr_sel;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count, wb_count;
`endif

    out_t  act;
    out_t  exp_q[$];
    string name_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    cache_control #(.s_index(3)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .hit(hit), .dirty(dirty), .lru(lru),
        .load_tag(load_tag), .load_valid(load_valid), .valid_in(valid_in),
        .load_dirty(load_dirty), .dirty_in(dirty_in), .load_lru(load_lru),
        .lru_in(lru_in), .load_data(load_data), .data_sel(data_sel),
        .addr_sel(addr_sel), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
    );

    always_comb begin
        act            = '0;
        act.mem_resp   = mem_resp;
        act.load_tag   = load_tag;
        act.load_valid = load_valid;
        act.load_dirty = load_dirty;
        act.dirty_in   = dirty_in;
        act.load_lru   = load_lru;
        act.lru_in     = lru_in;
        act.load_data  = load_data;
        act.data_sel   = data_sel;
        act.addr_sel   = addr_sel;
        act.pmem_read  = pmem_read;
        act.pmem_write = pmem_write;
        act.valid_in   = valid_in;
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            out_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL %s: got %h want %h", n, act, e);
            end
        end
    end

    function automatic out_t z();
        out_t e = '0;
        e.valid_in = 1'b1;
        return e;
    endfunction

    function automatic out_t rhit(input logic w);
        out_t e = z();
        e.mem_resp = 1'b1;
        e.load_lru = 1'b1;
        e.lru_in   = ~w;
        return e;
    endfunction

    function automatic out_t whit(input logic w);
        out_t e = rhit(w);
        e.load_data[w]  = 1'b1;
        e.load_dirty[w] = 1'b1;
        e.dirty_in      = 1'b1;
        return e;
    endfunction

    function automatic out_t wb(input logic v);
        out_t e = z();
        e.pmem_write = 1'b1;
        e.addr_sel   = v ? 2'd2 : 2'd1;
        return e;
    endfunction

    function automatic out_t fl();
        out_t e = z();
        e.pmem_read = 1'b1;
        return e;
    endfunction

    function automatic out_t fill_done(input logic v);
        out_t e = fl();
        e.load_tag[v]   = 1'b1;
        e.load_valid[v] = 1'b1;
        e.load_data[v]  = 1'b1;
        e.load_dirty[v] = 1'b1;
        e.data_sel      = 1'b1;
        return e;
    endfunction

    // One cycle: drive inputs just after the edge, queue the expected outputs.
    task automatic cyc(input logic rs, input logic r, input logic w, input logic [1:0] h,
                       input logic [1:0] d, input logic l, input logic pr,
                       input out_t e, input string nm);
        #1;
        rst = rs; mem_read = r; mem_write = w; hit = h; dirty = d; lru = l; pmem_resp = pr;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
    endtask

`ifdef CACHE_STATS_EN
    task automatic chk32(input logic [31:0] got, input logic [31:0] want, input string nm);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask
`endif

    initial begin
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; hit = 2'b00;
        dirty = 2'b00; lru = 1'b0; pmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        cyc(0, 0, 0, 2'b00, 2'b00, 0, 0, z(), "reset_state");

        // hits
        cyc(1, 1, 0, 2'b01, 2'b00, 0, 0, rhit(0), "read_hit_w0");
        cyc(1, 0, 1, 2'b10, 2'b00, 0, 0, whit(1), "write_hit_w1");
        cyc(1, 0, 0, 2'b00, 2'b00, 0, 0, z(), "idle_no_req");
        cyc(1, 1, 0, 2'b11, 2'b00, 1, 0, rhit(0), "hit11_way0_wins");
        cyc(1, 1, 1, 2'b01, 2'b00, 0, 0, whit(0), "rd_wr_is_write");

        // clean read miss, victim way 0; lru changes mid-miss must not matter
        cyc(1, 1, 0, 2'b00, 2'b00, 0, 0, z(), "m1_idle_miss");
        for (int i = 0; i < 4; i++)
            cyc(1, 1, 0, 2'b00, 2'b00, 1, 0, fl(), "m1_fill_wait");
        cyc(1, 1, 0, 2'b00, 2'b00, 1, 1, fill_done(0), "m1_fill_resp");
        cyc(1, 1, 0, 2'b01, 2'b00, 1, 0, rhit(0), "m1_hit_after_fill");
        cyc(1, 0, 0, 2'b00, 2'b00, 0, 1, z(), "idle_pmem_resp_ignored");

        // dirty write miss, victim way 1
        cyc(1, 0, 1, 2'b00, 2'b10, 1, 0, z(), "m2_idle_miss");
        cyc(1, 0, 1, 2'b00, 2'b10, 0, 0, wb(1), "m2_wb_wait");
        cyc(1, 0, 1, 2'b00, 2'b10, 0, 1, wb(1), "m2_wb_resp");
        cyc(1, 0, 1, 2'b00, 2'b10, 0, 0, fl(), "m2_fill_wait");
        cyc(1, 0, 1, 2'b00, 2'b10, 0, 1, fill_done(1), "m2_fill_resp");
        cyc(1, 0, 1, 2'b10, 2'b10, 0, 0, whit(1), "m2_hit_write");

        // reset pulsed mid-FILL
        cyc(1, 1, 0, 2'b00, 2'b00, 0, 0, z(), "m3_idle_miss");
        cyc(1, 1, 0, 2'b00, 2'b00, 0, 0, fl(), "m3_fill_wait");
        cyc(0, 1, 0, 2'b00, 2'b00, 0, 0, fl(), "m3_rst_in_fill");
        cyc(1, 0, 0, 2'b00, 2'b00, 0, 0, z(), "m3_idle_after_rst");
`ifdef CACHE_STATS_EN
        #1;
        chk32(hit_count, 32'd0, "rst_hit_count");
        chk32(miss_count, 32'd0, "rst_miss_count");
        chk32(wb_count, 32'd0, "rst_wb_count");
`endif

        // request dropped during WRITEBACK
        cyc(1, 1, 0, 2'b00, 2'b01, 0, 0, z(), "m4_idle_miss");
        cyc(1, 0, 0, 2'b00, 2'b01, 0, 0, wb(0), "m4_wb_dropped");
        cyc(1, 0, 0, 2'b00, 2'b01, 0, 1, wb(0), "m4_wb_resp");
        cyc(1, 0, 0, 2'b00, 2'b01, 0, 0, fl(), "m4_fill_wait");
        cyc(1, 0, 0, 2'b00, 2'b01, 0, 1, fill_done(0), "m4_fill_resp");
        cyc(1, 0, 0, 2'b01, 2'b00, 0, 0, z(), "m4_no_mem_resp");
`ifdef CACHE_STATS_EN
        #1;
        chk32(hit_count, 32'd0, "drop_hit_count");
        chk32(miss_count, 32'd1, "drop_miss_count");
        chk32(wb_count, 32'd1, "drop_wb_count");
`endif

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
